// File: rtl/raw_line_tap.sv
// Line-buffer tap for Bayer binning: pairs each raw pixel with the same-column
// pixel of the previous line, plus column/row parity, one cycle after input.
module raw_line_tap #(
  parameter int LINE_WIDTH = 640,
  parameter int DATA_W     = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iFVAL,
  output logic [DATA_W-1:0] oD0,
  output logic [DATA_W-1:0] oD1,
  output logic              oX,
  output logic              oY,
  output logic              oDVAL,
  output logic              oLINE_ERR
);
  localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

  logic [DATA_W-1:0] r_ram [LINE_WIDTH];
  logic [DATA_W-1:0] r_rd;
  logic [DATA_W-1:0] r_d0;
  logic [COL_W-1:0]  r_col;
  logic              r_row;
  logic              r_first;
  logic              r_dval_d;
  logic              r_fval_d;
  logic              r_mask;
  logic              r_x;
  logic              r_y;
  logic              r_dval;
  logic              r_err;

  logic w_acc;
  logic w_short;

  assign w_acc   = iFVAL & iDVAL;
  // Line ended early: valid dropped mid-line while the frame is still open.
  assign w_short = r_dval_d & ~iDVAL & iFVAL & r_fval_d & (r_col != '0);

  // Block-RAM style: registered read, read-before-write on the same address.
  always_ff @(posedge CLK) begin
    if (w_acc) begin
      r_rd         <= r_ram[r_col];
      r_ram[r_col] <= iDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_col    <= '0;
      r_row    <= 1'b0;
      r_first  <= 1'b1;
      r_dval_d <= 1'b0;
      r_fval_d <= 1'b0;
      r_d0     <= '0;
      r_mask   <= 1'b1;
      r_x      <= 1'b0;
      r_y      <= 1'b0;
      r_dval   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dval_d <= iDVAL;
      r_fval_d <= iFVAL;
      r_dval   <= w_acc;
      r_err    <= w_short;
      if (w_acc) begin
        r_d0   <= iDATA;
        r_mask <= r_first;
        r_x    <= r_col[0];
        r_y    <= r_row;
      end
      if (!iFVAL) begin
        r_col   <= '0;
        r_row   <= 1'b0;
        r_first <= 1'b1;
      end else if (w_acc) begin
        if (r_col == COL_LAST) begin
          r_col   <= '0;
          r_row   <= ~r_row;
          r_first <= 1'b0;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (w_short) begin
        r_col   <= '0;
        r_row   <= ~r_row;
        r_first <= 1'b0;
      end
    end
  end

  // The mask also hides uninitialised RAM contents on the first line after reset.
  assign oD0       = r_d0;
  assign oD1       = r_mask ? '0 : r_rd;
  assign oX        = r_x;
  assign oY        = r_y;
  assign oDVAL     = r_dval;
  assign oLINE_ERR = r_err;
endmodule

// File: tb/tb_raw_line_tap.sv
// Directed bench for raw_line_tap with a 4-pixel line.
module tb_raw_line_tap;
  localparam int LW = 4;
  localparam int DW = 10;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic          iFVAL;
  logic [DW-1:0] oD0;
  logic [DW-1:0] oD1;
  logic          oX;
  logic          oY;
  logic          oDVAL;
  logic          oLINE_ERR;

  int ncmp = 0;
  int nerr = 0;

  raw_line_tap #(.LINE_WIDTH(LW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .iDATA(iDATA), .iDVAL(iDVAL), .iFVAL(iFVAL),
    .oD0(oD0), .oD1(oD1), .oX(oX), .oY(oY), .oDVAL(oDVAL), .oLINE_ERR(oLINE_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int d, input logic v, input logic f);
    iDATA = DW'(d);
    iDVAL = v;
    iFVAL = f;
    @(posedge CLK);
    #1;
  endtask

  // Vector layout: {dval, d0, d1, x, y, err}
  task automatic chk(input string tag, input logic dv, input int d0, input int d1,
                     input logic x, input logic y, input logic err);
    logic [2*DW+3:0] got;
    logic [2*DW+3:0] exp;
    got = {oDVAL, oD0, oD1, oX, oY, oLINE_ERR};
    exp = {dv, DW'(d0), DW'(d1), x, y, err};
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed dval=%0b d0=%h d1=%h x=%0b y=%0b err=%0b expected dval=%0b d0=%h d1=%h x=%0b y=%0b err=%0b",
             tag, got[2*DW+3], got[2*DW+2:DW+3], got[DW+2:3], got[2], got[1], got[0],
             exp[2*DW+3], exp[2*DW+2:DW+3], exp[DW+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    iDATA = '0;
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("reset", 0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;

    // iDVAL while frame idle is ignored
    cyc(5, 1, 0);
    chk("idle_dval", 0, 0, 0, 0, 0, 0);

    // Frame A: 3 lines, no blanking
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < LW; c++) begin
        cyc(l*LW + c, 1, 1);
        chk($sformatf("fa_l%0d_c%0d", l, c), 1, l*LW + c,
            (l == 0) ? 0 : (l-1)*LW + c, 1'(c & 1), 1'(l & 1), 0);
      end
    cyc(0, 0, 0);
    chk("fa_end_hold", 0, 11, 7, 1, 0, 0);

    // Frame B: 2 idle cycles between lines
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < LW; c++) begin
        cyc(16 + l*LW + c, 1, 1);
        chk($sformatf("fb_l%0d_c%0d", l, c), 1, 16 + l*LW + c,
            (l == 0) ? 0 : 16 + (l-1)*LW + c, 1'(c & 1), 1'(l & 1), 0);
      end
      for (int g = 0; g < 2; g++) begin
        cyc(0, 0, 1);
        chk($sformatf("fb_gap_l%0d_%0d", l, g), 0, 16 + l*LW + 3,
            (l == 0) ? 0 : 16 + (l-1)*LW + 3, 1, 1'(l & 1), 0);
      end
    end
    cyc(0, 0, 0);

    // Frame C: short line 1 (2 pixels)
    for (int c = 0; c < LW; c++) begin
      cyc(32 + c, 1, 1);
      chk($sformatf("fc_l0_c%0d", c), 1, 32 + c, 0, 1'(c & 1), 0, 0);
    end
    cyc(36, 1, 1);
    chk("fc_l1_c0", 1, 36, 32, 0, 1, 0);
    cyc(37, 1, 1);
    chk("fc_l1_c1", 1, 37, 33, 1, 1, 0);
    cyc(0, 0, 1);
    chk("fc_line_err", 0, 37, 33, 1, 1, 1);
    cyc(0, 0, 1);
    chk("fc_err_one_shot", 0, 37, 33, 1, 1, 0);
    begin
      int exp_d1 [4] = '{36, 37, 34, 35};
      for (int c = 0; c < LW; c++) begin
        cyc(40 + c, 1, 1);
        chk($sformatf("fc_l2_c%0d", c), 1, 40 + c, exp_d1[c], 1'(c & 1), 0, 0);
      end
    end
    cyc(0, 0, 0);
    chk("fc_end_no_err", 0, 43, 35, 1, 0, 0);

    // Frame D: iFVAL drops mid-line 1, then new frame
    for (int c = 0; c < LW; c++) cyc(48 + c, 1, 1);
    cyc(52, 1, 1);
    cyc(53, 1, 1);
    chk("fd_l1_c1", 1, 53, 49, 1, 1, 0);
    cyc(0, 0, 0);
    chk("fd_drop", 0, 53, 49, 1, 1, 0);
    cyc(0, 0, 0);
    chk("fd_drop_no_err", 0, 53, 49, 1, 1, 0);
    for (int c = 0; c < LW; c++) begin
      cyc(56 + c, 1, 1);
      chk($sformatf("fd_new_c%0d", c), 1, 56 + c, 0, 1'(c & 1), 0, 0);
    end
    cyc(0, 0, 0);

    // Frame E: reset at col 2 of line 1
    for (int c = 0; c < LW; c++) cyc(64 + c, 1, 1);
    cyc(68, 1, 1);
    cyc(69, 1, 1);
    chk("fe_l1_c1", 1, 69, 65, 1, 1, 0);
    RST_N = 1'b0;
    cyc(70, 1, 1);
    chk("fe_reset_zero", 0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    cyc(0, 0, 1);
    chk("fe_post_reset", 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < LW; c++) begin
      cyc(72 + c, 1, 1);
      chk($sformatf("fe_first_c%0d", c), 1, 72 + c, 0, 1'(c & 1), 0, 0);
    end
    cyc(0, 0, 0);

    // Latency: single pixel 0x3FF
    cyc(0, 0, 1);
    chk("lat_pre", 0, 75, 0, 1, 0, 0);
    cyc(10'h3FF, 1, 1);
    chk("lat_pix", 1, 10'h3FF, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      chk($sformatf("lat_after_%0d", k), 0, 10'h3FF, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/raw_line_tap.md
# raw_line_tap

Line-buffer tap generator that sits directly upstream of the Bayer-to-RGB binning stage in the camera pipeline. It accepts the sensor's raw 10-bit pixel stream and produces, per valid pixel:
- the current-line pixel;
- the vertically aligned pixel from the previous line;
- column and row parity bits.

All four outputs are aligned with a delayed data-valid, so the binning stage can pair each 2×2 Bayer quad.

## Interface
- LINE_WIDTH, 640: active pixels per line; sets line-buffer depth and column wrap point.
- DATA_W, 10: raw pixel width.
- CLK  input  1  pixel clock; single clock domain.
- RST_N  input  1  reset, synchronous, active-low.
- iDATA  input  DATA_W  raw Bayer pixel.
- iDVAL  input  1  iDATA valid this cycle.
- iFVAL  input  1  frame valid; low between frames.
- oD0  output  DATA_W  current-line pixel, registered.
- oD1  output  DATA_W  same-column pixel from previous line; 0 on first line of frame.
- oX  output  1  column parity (column index bit 0) of oD0.
- oY  output  1  row parity (row index bit 0) of oD0.
- oDVAL  output  1  oD0/oD1/oX/oY valid.
- oLINE_ERR  output  1  one-cycle pulse when a line ends short of LINE_WIDTH pixels.

## Operation
- State: column counter col (ceil(log2(LINE_WIDTH)) bits), row parity bit row, first_row flag, previous-cycle registers iDVAL_d and iFVAL_d, and a LINE_WIDTH × DATA_W line RAM.
- Reset (RST_N low at a CLK edge) clears the following: col=0, row=0, first_row=1, iDVAL_d=0, iFVAL_d=0, and all outputs to 0. RAM contents are not cleared.
  - Stale RAM data is masked because first_row=1 forces oD1=0.
- Frame idle (iFVAL=0): col=0, row=0, first_row=1; oDVAL=0; iDVAL is ignored.
- Frame start: a rising edge of iFVAL is treated as idle→active. Counters are already at their idle values.
- Pixel accept (iFVAL=1 and iDVAL=1):
  - RAM[col] is read (read-before-write) and is then written with iDATA.
  - Next cycle: oD0=iDATA, oD1 = first_row ? 0 : old RAM[col], oX=col[0], oY=row, oDVAL=1.
  - Then col increments.
- Line wrap: if col==LINE_WIDTH-1 on accept, then col←0, row←~row, first_row←0.
- Short line: iDVAL falling edge (iDVAL_d=1, iDVAL=0) with iFVAL=1 and col≠0.
  - Action: col←0, row←~row, first_row←0, and oLINE_ERR pulses high for one cycle.
  - RAM entries beyond the short length keep the older line's data.
- Frame end inside a line: iFVAL falls with col≠0. Return to idle; no oLINE_ERR pulse.
- A normal line's iDVAL falls after wrap with col=0 already; no error.
- Simultaneous accept on col==LINE_WIDTH-1 and iFVAL falling in the next cycle: the wrap completes normally, then the block goes idle.
- No back-pressure; the downstream stage must accept one pixel per cycle.
- Arithmetic: col and row are unsigned and wrap only via the rules above; col never exceeds LINE_WIDTH-1.

## Timing
- Latency: exactly 1 CLK from iDATA/iDVAL sample to oD0/oD1/oX/oY/oDVAL.
- Throughput: one pixel per cycle sustained, including back-to-back lines with no blanking.
- oDVAL=0 in any cycle following a non-accept cycle. oD0/oD1/oX/oY hold their last values when oDVAL=0.
- oLINE_ERR is asserted in the cycle after the short-line falling edge is detected, for one cycle only.
- The RAM must be read-before-write at the same address in the same cycle. It must map to inferred block RAM with a registered read port.
- Reset mid-line takes effect on the same edge it is sampled. The cycle after reset shows all outputs 0. The following line is treated as first_row.

## Test plan
- LINE_WIDTH=4, frame of 3 lines with pixels 0..11, no blanking:
  - line 0 → oD1=0, oY=0;
  - line 1 → oD0=4..7, oD1=0..3, oY=1;
  - line 2 → oD1=4..7, oY=0;
  - oX toggles 0,1,0,1 on every line.
- Same frame with 2 idle cycles between lines: oDVAL low during the gaps, outputs held, same oD1 pairing as above.
- Short line: LINE_WIDTH=4, line 1 stops after 2 pixels (iDVAL falls).
  - Required: oLINE_ERR pulses once.
  - Line 2 starts with oX=0, oY=0, and its oD1 = line 1's first two pixels followed by line 0's pixels 2,3.
- iFVAL drops mid-line 1 and a new frame starts: the first line of the new frame has oD1=0, oY=0, oX starting at 0, and oLINE_ERR stays 0.
- RST_N low for one cycle at col=2 of line 1:
  - the next output cycle shows all zeros;
  - the following line gives oD1=0 and oY=0.
- Latency check: a single pixel 0x3FF on col 0 → oDVAL=1, oD0=0x3FF exactly one cycle later; no other oDVAL pulse.
